// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for a 4-bit universal shift register: accepts one
// load/shift command per handshake and sequences Sel/fill/parallel data.
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic             Cmd_Load,
  input  logic             Cmd_Dir,
  input  logic             Cmd_Fill,
  input  logic [CNT_W-1:0] Cmd_Count,
  input  logic [WIDTH-1:0] Cmd_Data,
  input  logic             Abort,
  output logic [1:0]       Sel,
  output logic [WIDTH-1:0] P_Out,
  output logic             Fill_Msb,
  output logic             Fill_Lsb,
  output logic             Busy,
  output logic             Done,
  output logic             Aborted,
  output logic [CNT_W-1:0] Remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_dir;
  logic             r_fill;
  logic             r_aborted;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  assign w_accept  = Cmd_Valid && (r_state == S_IDLE);
  assign P_Out     = r_data;
  assign Remaining = r_remaining;

  // NOTE: every output gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    Cmd_Ready    = 1'b0;
    Sel          = SEL_HOLD;
    Fill_Msb     = 1'b0;
    Fill_Lsb     = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    Aborted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        Cmd_Ready = 1'b1;
        if (w_accept) begin
          if (Cmd_Load)               w_next_state = S_LOAD;
          else if (Cmd_Count != '0)   w_next_state = S_SHIFT;
          else                        w_next_state = S_DONE;
        end
      end
      S_LOAD: begin
        Sel  = SEL_LOAD;
        Busy = 1'b1;
        if (Abort || (r_remaining == '0)) w_next_state = S_DONE;
        else                              w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        Sel      = r_dir ? SEL_LEFT : SEL_RIGHT;
        Busy     = 1'b1;
        Fill_Msb = !r_dir && r_fill;
        Fill_Lsb = r_dir && r_fill;
        // Remaining<=1 rather than ==1 so a corrupted count can never hang here.
        if (Abort || (r_remaining <= CNT_W'(1))) w_next_state = S_DONE;
      end
      S_DONE: begin
        Done         = 1'b1;
        Aborted      = r_aborted;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_fill      <= 1'b0;
      r_aborted   <= 1'b0;
      r_remaining <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir       <= Cmd_Dir;
            r_fill      <= Cmd_Fill;
            r_remaining <= Cmd_Count;
            r_data      <= Cmd_Data;
            r_aborted   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (Abort) begin
            r_remaining <= '0;
            r_aborted   <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (Abort) begin
            r_remaining <= '0;
            r_aborted   <= 1'b1;
          end else if (r_remaining != '0) begin
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: drives directed and random commands into the
// controller paired with a 4-bit shift register and compares against a cycle model.
module tb_usr_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             Cmd_Valid = 1'b0;
  logic             Cmd_Ready;
  logic             Cmd_Load = 1'b0;
  logic             Cmd_Dir = 1'b0;
  logic             Cmd_Fill = 1'b0;
  logic [CNT_W-1:0] Cmd_Count = '0;
  logic [WIDTH-1:0] Cmd_Data = '0;
  logic             Abort = 1'b0;
  logic [1:0]       Sel;
  logic [WIDTH-1:0] P_Out;
  logic             Fill_Msb;
  logic             Fill_Lsb;
  logic             Busy;
  logic             Done;
  logic             Aborted;
  logic [CNT_W-1:0] Remaining;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_sr = 4'h0;
  logic [3:0] sr;

  usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Load(Cmd_Load), .Cmd_Dir(Cmd_Dir), .Cmd_Fill(Cmd_Fill),
    .Cmd_Count(Cmd_Count), .Cmd_Data(Cmd_Data), .Abort(Abort), .Sel(Sel),
    .P_Out(P_Out), .Fill_Msb(Fill_Msb), .Fill_Lsb(Fill_Lsb), .Busy(Busy),
    .Done(Done), .Aborted(Aborted), .Remaining(Remaining)
  );

  always #5 Clk = ~Clk;

  // The controlled 4-bit universal shift register.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) sr <= 4'h0;
    else begin
      case (Sel)
        2'b01: sr <= {Fill_Msb, sr[3:1]};
        2'b10: sr <= {sr[2:0], Fill_Lsb};
        2'b11: sr <= P_Out;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // abort_idx: index into the busy cycles (load first, then shifts) during
  // which Abort is raised; negative means no abort.
  task automatic run_cmd(input bit load, input bit dir, input bit fill, input int count,
                         input logic [3:0] data, input int abort_idx);
    int  nbusy;
    bit  ab;
    bit  is_load;
    int  sj;
    @(negedge Clk);
    check("idle_ready", Cmd_Ready, 1);
    check("idle_sel", Sel, 0);
    Cmd_Valid = 1'b1; Cmd_Load = load; Cmd_Dir = dir; Cmd_Fill = fill;
    Cmd_Count = CNT_W'(count); Cmd_Data = data;
    nbusy = int'(load) + count;
    ab = 1'b0;
    if (abort_idx >= 0 && abort_idx < nbusy) begin
      nbusy = abort_idx + 1;
      ab = 1'b1;
    end
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    Cmd_Load = 1'($urandom); Cmd_Dir = 1'($urandom); Cmd_Fill = 1'($urandom);
    Cmd_Count = CNT_W'($urandom); Cmd_Data = WIDTH'($urandom);
    for (int i = 0; i < nbusy; i++) begin
      is_load = load && (i == 0);
      sj = i - int'(load);
      check("busy_sel", Sel, is_load ? 2'b11 : (dir ? 2'b10 : 2'b01));
      check("busy_busy", Busy, 1);
      check("busy_ready", Cmd_Ready, 0);
      check("busy_done", Done, 0);
      check("busy_rem", Remaining, is_load ? count : count - sj);
      check("busy_fmsb", Fill_Msb, (!is_load && !dir) ? fill : 1'b0);
      check("busy_flsb", Fill_Lsb, (!is_load && dir) ? fill : 1'b0);
      check("busy_reg", sr, exp_sr);
      Abort = ab && (i == nbusy - 1);
      @(negedge Clk);
      Abort = 1'b0;
      if (is_load)  exp_sr = data;
      else if (dir) exp_sr = 4'(((int'(exp_sr) << 1) | int'(fill)) & 15);
      else          exp_sr = 4'((int'(exp_sr) >> 1) | (int'(fill) << 3));
    end
    check("done_done", Done, 1);
    check("done_aborted", Aborted, ab);
    check("done_sel", Sel, 0);
    check("done_busy", Busy, 0);
    check("done_ready", Cmd_Ready, 0);
    check("done_rem", Remaining, 0);
    check("done_reg", sr, exp_sr);
    Abort = 1'($urandom);
    @(negedge Clk);
    check("post_done", Done, 0);
    check("post_aborted", Aborted, 0);
    check("post_ready", Cmd_Ready, 1);
    check("post_busy", Busy, 0);
    Abort = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_sel", Sel, 0);
    check("rst_pout", P_Out, 0);
    check("rst_fill", {Fill_Msb, Fill_Lsb}, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_aborted", Aborted, 0);
    check("rst_rem", Remaining, 0);
    @(negedge Clk);
    Rst = 1'b1;

    // Directed plan items.
    run_cmd(1'b1, 1'b0, 1'b0, 0, 4'b1011, -1);
    run_cmd(1'b1, 1'b0, 1'b0, 2, 4'b1011, -1);
    run_cmd(1'b1, 1'b0, 1'b0, 0, 4'b0000, -1);
    run_cmd(1'b0, 1'b1, 1'b1, 3, 4'b1010, -1);
    run_cmd(1'b1, 1'b1, 1'b0, 15, 4'b0110, 2);
    run_cmd(1'b1, 1'b0, 1'b1, 5, 4'b1001, 0);
    run_cmd(1'b0, 1'b0, 1'b1, 4, 4'b0000, 3);
    run_cmd(1'b0, 1'b0, 1'b0, 0, 4'b1111, -1);
    run_cmd(1'b0, 1'b1, 1'b0, 15, 4'b0000, -1);

    // Cmd_Valid held high on no-op commands: IDLE and DONE alternate.
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Load = 1'b0; Cmd_Count = '0;
    for (int k = 0; k < 6; k++) begin
      check("cont_ready", Cmd_Ready, (k % 2) == 0);
      check("cont_done", Done, (k % 2) == 1);
      check("cont_sel", Sel, 0);
      @(negedge Clk);
    end
    Cmd_Valid = 1'b0;
    check("cont_end_done", Done, 0);

    // Reset mid-SHIFT, between edges.
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Load = 1'b0; Cmd_Dir = 1'b0; Cmd_Fill = 1'b1; Cmd_Count = 4'd6;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    check("mid_busy_before", Busy, 1);
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("mid_rst_sel", Sel, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_rem", Remaining, 0);
    check("mid_rst_done", Done, 0);
    @(posedge Clk);
    #1 check("mid_rst_done2", Done, 0);
    @(negedge Clk);
    Rst = 1'b1;
    exp_sr = 4'h0;
    run_cmd(1'b1, 1'b1, 1'b1, 2, 4'b0101, -1);

    // Random commands against the cycle model.
    for (int n = 0; n < 25; n++) begin
      run_cmd(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
              4'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
